// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Multi-channel mechanical key debouncer. Each channel synchronises its raw
// asynchronous key level, normalises it so that 1 means "pressed", and only
// accepts a new level once it has been seen on STABLE_CYCLES consecutive
// enabled samples. Accepted changes are reported on key_state together with a
// one-cycle key_press / key_release pulse.
//
// Parameters
//   CH            number of independent key channels (>= 1)
//   SYNC_STAGES   synchroniser depth per channel (>= 2)
//   CNT_W         width of the per-channel stability counter
//   STABLE_CYCLES qualifying samples required (1 .. 2^CNT_W-1)
//   ACTIVE_LOW    1: raw low = pressed, 0: raw high = pressed
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   nrst         synchronous active-low reset
//   sample_en    sample strobe; stability counters advance only when high
//   key_in       raw asynchronous key levels, one bit per channel
//   key_state    debounced level, 1 = pressed
//   key_press    one-cycle pulse on debounced released->pressed
//   key_release  one-cycle pulse on debounced pressed->released
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int CH            = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          sample_en,
    input  logic [CH-1:0] key_in,
    output logic [CH-1:0] key_state,
    output logic [CH-1:0] key_press,
    output logic [CH-1:0] key_release
);

    // Raw level of a released key; also the synchroniser reset value so a
    // reset never looks like a key event.
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'sd1);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (CH < 1) begin : g_bad_ch
        $error("key_debounce: CH must be >= 1");
    end

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("key_debounce: SYNC_STAGES must be >= 2");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("key_debounce: CNT_W must be >= 1");
    end

    if (STABLE_CYCLES < 1) begin : g_bad_stable_lo
        $error("key_debounce: STABLE_CYCLES must be >= 1");
    end

    // Only widths below 31 can be exceeded by a positive int parameter.
    if ((CNT_W < 31) && (STABLE_CYCLES > ((32'sd1 <<< CNT_W) - 32'sd1))) begin : g_bad_stable_hi
        $error("key_debounce: STABLE_CYCLES must be <= 2^CNT_W-1");
    end

    // -------------------------------------------------------------------------
    // Per-channel debounce slice; channels share nothing but clock and strobe
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < CH; i++) begin : g_ch

        logic [SYNC_STAGES-1:0] sync_r;
        logic                   norm_s;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_nxt_s;
        logic                   state_r;
        logic                   state_nxt_s;
        logic                   press_r;
        logic                   press_nxt_s;
        logic                   release_r;
        logic                   release_nxt_s;

        // Synchroniser shift chain; bit 0 takes the raw input, the top bit is
        // the oldest, metastability-settled sample.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                sync_r <= {SYNC_STAGES{IDLE_LVL}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], key_in[i]};
            end
        end

        // Normalised level: 1 = pressed regardless of key polarity.
        assign norm_s = sync_r[SYNC_STAGES-1] ^ IDLE_LVL;

        // Stability qualification: count enabled mismatching samples and
        // accept the new level on the last one. Any sample agreeing with the
        // accepted level discards progress, even when the strobe is low.
        always_comb begin
            cnt_nxt_s     = cnt_r;
            state_nxt_s   = state_r;
            press_nxt_s   = 1'b0;
            release_nxt_s = 1'b0;
            if (norm_s == state_r) begin
                cnt_nxt_s = CNT_ZERO;
            end else if (sample_en) begin
                // >= rather than == so a corrupted counter can never run
                // past the terminal value.
                if (cnt_r >= CNT_LAST) begin
                    cnt_nxt_s     = CNT_ZERO;
                    state_nxt_s   = norm_s;
                    press_nxt_s   = norm_s;
                    release_nxt_s = ~norm_s;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

        // Counter, debounced level and event pulse registers.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                cnt_r     <= CNT_ZERO;
                state_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                cnt_r     <= cnt_nxt_s;
                state_r   <= state_nxt_s;
                press_r   <= press_nxt_s;
                release_r <= release_nxt_s;
            end
        end

        assign key_state[i]   = state_r;
        assign key_press[i]   = press_r;
        assign key_release[i] = release_r;

    end

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Self-checking bench for key_debounce. The main instance (CH=4, SYNC=2,
// STABLE=8, active-low keys) is driven by a table of directed vectors, a few
// hand-written strobe sequences and a randomised phase. A second instance
// (CH=2, SYNC=3, STABLE=1, active-high keys) runs on random stimulus for the
// whole test. Both are compared every cycle against behavioural models.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    logic       clk;
    logic       nrst;
    logic       sample_en;
    logic [3:0] key_in;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;

    logic       sample_en1;
    logic [1:0] key_in1;
    logic [1:0] key_state1;
    logic [1:0] key_press1;
    logic [1:0] key_release1;

    int n_tests = 0;
    int n_fail  = 0;

    key_debounce #(
        .CH(4), .SYNC_STAGES(2), .CNT_W(16), .STABLE_CYCLES(8), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .nrst(nrst), .sample_en(sample_en), .key_in(key_in),
        .key_state(key_state), .key_press(key_press), .key_release(key_release)
    );

    key_debounce #(
        .CH(2), .SYNC_STAGES(3), .CNT_W(4), .STABLE_CYCLES(1), .ACTIVE_LOW(0)
    ) dut1 (
        .clk(clk), .nrst(nrst), .sample_en(sample_en1), .key_in(key_in1),
        .key_state(key_state1), .key_press(key_press1), .key_release(key_release1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------------------------------------------------------------
    // Behavioural models: a delay line of raw samples, the accepted level,
    // and a run length of enabled samples disagreeing with that level.
    // ---------------------------------------------------------------------
    bit [3:0] m_pipe [$];
    bit [3:0] m_state, m_press, m_rel, m_lvl;
    int       m_run [4];
    bit [1:0] m1_pipe [$];
    bit [1:0] m1_state, m1_press, m1_rel, m1_lvl;
    bit       model_ok = 1'b0;

    always @(posedge clk) begin
        if (!nrst) begin
            m_pipe = {};
            repeat (2) m_pipe.push_back(4'b1111);
            m_state = 4'b0000; m_press = 4'b0000; m_rel = 4'b0000;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
            m1_pipe = {};
            repeat (3) m1_pipe.push_back(2'b00);
            m1_state = 2'b00; m1_press = 2'b00; m1_rel = 2'b00;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_lvl = ~m_pipe.pop_front();
            m_pipe.push_back(key_in);
            m_press = 4'b0000; m_rel = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                if (m_lvl[c] == m_state[c]) begin
                    m_run[c] = 0;
                end else if (sample_en) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == 8) begin
                        m_state[c] = m_lvl[c];
                        if (m_lvl[c]) m_press[c] = 1'b1;
                        else          m_rel[c]   = 1'b1;
                        m_run[c] = 0;
                    end
                end
            end
            // Single qualifying sample: follow the level on any enabled edge.
            m1_lvl = m1_pipe.pop_front();
            m1_pipe.push_back(key_in1);
            m1_press = 2'b00; m1_rel = 2'b00;
            if (sample_en1) begin
                m1_press = m1_lvl & ~m1_state;
                m1_rel   = ~m1_lvl & m1_state;
                m1_state = m1_lvl;
            end
        end
    end

    // Every-cycle comparison against the models, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            n_tests++;
            if ({key_state, key_press, key_release} !== {m_state, m_press, m_rel}) begin
                n_fail++;
                $display("FAIL model_ch4 t=%0t: got state=%b press=%b release=%b, expected state=%b press=%b release=%b",
                         $time, key_state, key_press, key_release, m_state, m_press, m_rel);
            end
            n_tests++;
            if ({key_state1, key_press1, key_release1} !== {m1_state, m1_press, m1_rel}) begin
                n_fail++;
                $display("FAIL model_stable1 t=%0t: got state=%b press=%b release=%b, expected state=%b press=%b release=%b",
                         $time, key_state1, key_press1, key_release1, m1_state, m1_press, m1_rel);
            end
        end
    end

    // Random drive for the single-sample instance throughout the run.
    initial begin
        key_in1    = 2'b00;
        sample_en1 = 1'b1;
        forever begin
            @(negedge clk);
            key_in1    = 2'($urandom_range(0, 3));
            sample_en1 = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------------------------------------------------------------
    // Directed vectors
    // ---------------------------------------------------------------------
    typedef struct {
        logic       rst_lvl;
        logic       en;
        logic [3:0] key;
        int         cycles;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
    } vec_t;

    vec_t tbl [$];

    function automatic void add_vec(input logic r, input logic e, input logic [3:0] k,
                                    input int n, input logic [3:0] s,
                                    input logic [3:0] p, input logic [3:0] l);
        vec_t v;
        v.rst_lvl = r; v.en = e; v.key = k; v.cycles = n;
        v.st = s; v.pr = p; v.rl = l;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [3:0] st, input logic [3:0] pr,
                       input logic [3:0] rl);
        n_tests++;
        if (key_state !== st || key_press !== pr || key_release !== rl) begin
            n_fail++;
            $display("FAIL %s: got state=%b press=%b release=%b, expected state=%b press=%b release=%b",
                     nm, key_state, key_press, key_release, st, pr, rl);
        end
    endtask

    initial begin
        nrst      = 1'b0;
        sample_en = 1'b1;
        key_in    = 4'b0000;

        // Reset with all keys held pressed, then report them all.
        add_vec(1'b0, 1'b1, 4'b0000, 3,  4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 9,  4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 1,  4'b1111, 4'b1111, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 1,  4'b1111, 4'b0000, 4'b0000);
        // Clean release then press on ch0.
        add_vec(1'b1, 1'b1, 4'b0001, 9,  4'b1111, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0001, 1,  4'b1110, 4'b0000, 4'b0001);
        add_vec(1'b1, 1'b1, 4'b0001, 1,  4'b1110, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 10, 4'b1111, 4'b0001, 4'b0000);
        // Release ch1, bounce it for 30 cycles, then hold pressed.
        add_vec(1'b1, 1'b1, 4'b0010, 10, 4'b1101, 4'b0000, 4'b0010);
        add_vec(1'b1, 1'b1, 4'b0010, 1,  4'b1101, 4'b0000, 4'b0000);
        for (int b = 0; b < 10; b++)
            add_vec(1'b1, 1'b1, (b % 2 == 0) ? 4'b0000 : 4'b0010, 3, 4'b1101, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 9,  4'b1101, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b0000, 1,  4'b1111, 4'b0010, 4'b0000);
        // Simultaneous press ch2 / release ch3.
        add_vec(1'b1, 1'b1, 4'b0100, 10, 4'b1011, 4'b0000, 4'b0100);
        add_vec(1'b1, 1'b1, 4'b1000, 9,  4'b1011, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b1000, 1,  4'b0111, 4'b0100, 4'b1000);
        // Reset with ch0 counter at 5.
        add_vec(1'b1, 1'b1, 4'b1001, 10, 4'b0110, 4'b0000, 4'b0001);
        add_vec(1'b1, 1'b1, 4'b1000, 7,  4'b0110, 4'b0000, 4'b0000);
        add_vec(1'b0, 1'b1, 4'b1000, 1,  4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b1000, 9,  4'b0000, 4'b0000, 4'b0000);
        add_vec(1'b1, 1'b1, 4'b1000, 1,  4'b0111, 4'b0111, 4'b0000);

        foreach (tbl[i]) begin
            nrst      = tbl[i].rst_lvl;
            sample_en = tbl[i].en;
            key_in    = tbl[i].key;
            repeat (tbl[i].cycles) @(negedge clk);
            chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].pr, tbl[i].rl);
        end

        // Strobe 1-in-4: release ch2 qualifies on the 8th enabled sample
        // after the synchroniser, i.e. edge 33.
        key_in = 4'b1100;
        for (int k = 1; k <= 33; k++) begin
            sample_en = (k % 4 == 1);
            @(negedge clk);
            if (k == 32) chk("strobe_wait", 4'b0111, 4'b0000, 4'b0000);
        end
        chk("strobe_release", 4'b0011, 4'b0000, 4'b0100);

        // Partial count (4 enabled samples) on ch2 press, then restore the
        // level with the strobe low: the count must still be discarded.
        key_in = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            sample_en = (k % 4 == 1);
            @(negedge clk);
        end
        sample_en = 1'b0;
        key_in    = 4'b1100;
        repeat (4) @(negedge clk);
        chk("strobe_restore", 4'b0011, 4'b0000, 4'b0000);
        key_in = 4'b1000;
        repeat (2) @(negedge clk);
        sample_en = 1'b1;
        repeat (7) @(negedge clk);
        chk("strobe_cleared", 4'b0011, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("strobe_press", 4'b0111, 4'b0100, 4'b0000);

        // Randomised phase with slow key changes, bounces and rare resets.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            nrst      = ($urandom_range(0, 599) != 0);
            sample_en = ($urandom_range(0, 5) != 0);
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 19) == 0) key_in[c] = ~key_in[c];
            @(negedge clk);
        end
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CH, default 4, number of independent key channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel (>=2).
REQ-003 Parameter CNT_W, default 16, stability counter width.
REQ-004 Parameter STABLE_CYCLES, default 50000, qualifying samples required (1 <= STABLE_CYCLES <= 2^CNT_W-1).
REQ-005 Parameter ACTIVE_LOW, default 1: 1 = raw key low means pressed; 0 = raw key high means pressed.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 nrst  input  1  reset, synchronous, active-low.
REQ-008 sample_en  input  1  sample strobe; counters advance only when high; tie high for per-clock counting.
REQ-009 key_in  input  CH  raw asynchronous key levels.
REQ-010 key_state  output  CH  debounced level, normalised 1 = pressed.
REQ-011 key_press  output  CH  one-cycle pulse on debounced released->pressed.
REQ-012 key_release  output  CH  one-cycle pulse on debounced pressed->released.

Function
REQ-013 Each channel SHALL pass key_in[i] through SYNC_STAGES flops, then XOR with ACTIVE_LOW, giving normalised level n[i] (1 = pressed).
REQ-014 Channels SHALL be fully independent; no shared counters or arbitration.
REQ-015 Per channel: n[i] == key_state[i] -> counter cleared to 0 that cycle, regardless of sample_en.
REQ-016 n[i] != key_state[i], sample_en=1, counter < STABLE_CYCLES-1 -> counter +1.
REQ-017 n[i] != key_state[i], sample_en=1, counter == STABLE_CYCLES-1 -> next cycle: key_state[i] <= n[i], counter <= 0, matching pulse output high.
REQ-018 n[i] != key_state[i], sample_en=0 -> counter holds.
REQ-019 Counter SHALL never wrap or exceed STABLE_CYCLES-1.
REQ-020 key_press[i] and key_release[i] SHALL be registered, high exactly one cycle, asserted in the same cycle key_state[i] changes, never both high together.
REQ-021 Latency, sample_en=1: key_state[i] changes exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge sampling the new key_in[i] level, provided the level holds.
REQ-022 Any return of n[i] to key_state[i] before qualification SHALL discard accumulated count (bounce restart).
REQ-023 STABLE_CYCLES=1: key_state SHALL follow n[i] on the first mismatched enabled sample.
REQ-024 Parameter violations (SYNC_STAGES<2, STABLE_CYCLES out of range) SHALL fail elaboration.

Reset
REQ-025 nrst low at a rising edge SHALL set: key_state=0, key_press=0, key_release=0, all counters=0, all synchroniser flops=ACTIVE_LOW (released level).
REQ-026 Reset mid-count SHALL discard progress; qualification restarts from zero after nrst returns high.
REQ-027 Key held pressed through reset SHALL be reported by a key_press pulse SYNC_STAGES+STABLE_CYCLES cycles after nrst deasserts (sample_en=1).
REQ-028 Outputs SHALL be undefined-free from the first edge with nrst low; no asynchronous reset path.

Verification (CH=4, SYNC_STAGES=2, STABLE_CYCLES=8, ACTIVE_LOW=1, sample_en=1 unless stated)
REQ-029 Reset: key_in=4'b0000, nrst low 3 cycles -> all outputs 0 during reset; key_press=4'b1111 for one cycle exactly 10 cycles after nrst high; key_state=4'b1111 thereafter.
REQ-030 Clean press/release ch0: key_in[0] 1->0 held -> key_state[0]=1 and key_press[0] pulse 10 cycles later; 1 again held -> key_release[0] pulse 10 cycles later.
REQ-031 Bounce: key_in[1] toggles every 3 cycles for 30 cycles -> no key_state change, no pulses; then held 0 -> key_press[1] 10 cycles after last toggle.
REQ-032 Strobe: sample_en high 1 cycle in 4 -> qualification needs 8 enabled samples after synchroniser; sample_en low with level restored mid-count -> counter still clears.
REQ-033 Simultaneous: same edge press ch2, release ch3 (from pressed) -> key_press[2] and key_release[3] pulse in the same cycle; ch0/ch1 unaffected.
REQ-034 Reset mid-count: ch0 counter at 5, nrst low 1 cycle -> no pulse; key_press[0] 10 cycles after nrst high.
